// File: rtl/spi_cmem_bridge.sv
// spi_cmem_bridge: SPI mode-0 slave that lets the Pi read and write the 16x4-bit
// command memory. SPI pins are oversampled in the clk200 domain, one command byte
// per transaction selects single/burst read/write, and single-cycle strobes drive
// the cmem SPI-side port. Read data returns on MISO as {4'b0, data}.
`timescale 1ns/1ps
module spi_cmem_bridge (
   input  logic       clk200,
   input  logic       reset,
   input  logic       SPI_CS_n,
   input  logic       SPI_SCK,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   output logic       spi_read,
   output logic       spi_write,
   output logic [3:0] spi_address,
   output logic [3:0] spi_out_cmem_in,
   input  logic [3:0] spi_in_cmem_out
);

   localparam int unsigned AW = 4;
   localparam int unsigned BW = 8;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_t;

   state_t          state;
   state_t          state_nxt;

   logic            cs_s1, cs_s2;
   logic            sck_s1, sck_s2, sck_s3;
   logic            mosi_s1, mosi_s2;

   logic [BW-2:0]   rx_shift;
   logic [BW-1:0]   rx_byte;
   logic [CW-1:0]   bit_cnt, bit_cnt_n;
   logic [CW-1:0]   fall_cnt, fall_cnt_n;
   logic [BW-1:0]   tx_shift;
   logic [BW-1:0]   tx_next;
   logic            tx_pend;
   logic            tx_load;
   logic            rd_dly;

   logic [AW-1:0]   addr;
   logic            op_write;
   logic            op_burst;

   logic            active;
   logic            rise_ok;
   logic            fall_ok;
   logic            byte_done;
   logic            cmd_start;
   logic            op_legal;

   logic            rd_c;
   logic            wr_c;
   logic [AW-1:0]   strobe_addr_c;
   logic [AW-1:0]   wdata_c;
   logic [AW-1:0]   addr_nxt_c;

   // Two-flop synchronizers on all SPI inputs plus a history flop on SCK.
   always_ff @(posedge clk200 or posedge reset) begin
      if (reset) begin
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         sck_s1  <= 1'b0;
         sck_s2  <= 1'b0;
         sck_s3  <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         cs_s1   <= SPI_CS_n;
         cs_s2   <= cs_s1;
         sck_s1  <= SPI_SCK;
         sck_s2  <= sck_s1;
         sck_s3  <= sck_s2;
         mosi_s1 <= SPI_MOSI;
         mosi_s2 <= mosi_s1;
      end
   end

   // Edges only count while selected; a deselect in the same cycle wins.
   assign active     = (state != IDLE) && !cs_s2;
   assign rise_ok    = active && sck_s2 && !sck_s3;
   assign fall_ok    = active && !sck_s2 && sck_s3;
   assign byte_done  = rise_ok && (bit_cnt == CW'(7));
   assign rx_byte    = {rx_shift, mosi_s2};
   assign cmd_start  = (state == IDLE) && !cs_s2;
   assign op_legal   = (rx_byte[7:6] == 2'b00);
   assign bit_cnt_n  = bit_cnt + CW'(rise_ok);
   assign fall_cnt_n = fall_cnt + CW'(fall_ok);
   assign tx_load    = rd_dly && active;

   // FSM state register.
   always_ff @(posedge clk200 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!cs_s2) state_nxt = CMD;
         CMD:     if (cs_s2) state_nxt = IDLE;
                  else if (byte_done) state_nxt = op_legal ? DATA : DISCARD;
         DATA:    if (cs_s2) state_nxt = IDLE;
                  else if (byte_done && !op_burst) state_nxt = DISCARD;
         DISCARD: if (cs_s2) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM output logic: strobe requests and address bookkeeping per completed byte.
   always_comb begin
      rd_c          = 1'b0;
      wr_c          = 1'b0;
      strobe_addr_c = addr;
      wdata_c       = rx_byte[3:0];
      addr_nxt_c    = addr;
      case (state)
         IDLE: addr_nxt_c = '0;
         CMD: begin
            if (byte_done) begin
               addr_nxt_c    = rx_byte[3:0];
               strobe_addr_c = rx_byte[3:0];
               rd_c          = op_legal && !rx_byte[4];
            end
         end
         DATA: begin
            if (byte_done) begin
               if (op_write) begin
                  wr_c          = 1'b1;
                  strobe_addr_c = addr;
                  addr_nxt_c    = addr + AW'(1);
               end else if (op_burst) begin
                  rd_c          = 1'b1;
                  strobe_addr_c = addr + AW'(1);
                  addr_nxt_c    = addr + AW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // Registered cmem strobes, address/data and opcode capture.
   always_ff @(posedge clk200 or posedge reset) begin
      if (reset) begin
         spi_read        <= 1'b0;
         spi_write       <= 1'b0;
         spi_address     <= '0;
         spi_out_cmem_in <= '0;
         addr            <= '0;
         rd_dly          <= 1'b0;
         op_write        <= 1'b0;
         op_burst        <= 1'b0;
      end else begin
         spi_read  <= rd_c;
         spi_write <= wr_c;
         if (rd_c || wr_c) spi_address <= strobe_addr_c;
         if (wr_c) spi_out_cmem_in <= wdata_c;
         addr   <= addr_nxt_c;
         rd_dly <= spi_read;
         if ((state == CMD) && byte_done) begin
            op_write <= rx_byte[4];
            op_burst <= rx_byte[5];
         end
      end
   end

   // Serial shifters. Read data arriving between the 8th rise and 8th fall is
   // parked until that fall; data arriving later is pre-shifted by the falls
   // already seen so MISO stays bit-aligned.
   always_ff @(posedge clk200 or posedge reset) begin
      if (reset) begin
         rx_shift <= '0;
         bit_cnt  <= '0;
         fall_cnt <= '0;
         tx_shift <= '0;
         tx_next  <= '0;
         tx_pend  <= 1'b0;
      end else if (cmd_start) begin
         rx_shift <= '0;
         bit_cnt  <= '0;
         fall_cnt <= '0;
         tx_shift <= '0;
         tx_next  <= '0;
         tx_pend  <= 1'b0;
      end else begin
         if (rise_ok) begin
            rx_shift <= rx_byte[BW-2:0];
            bit_cnt  <= bit_cnt_n;
         end
         if (fall_ok) begin
            fall_cnt <= fall_cnt_n;
            if (tx_pend) begin
               tx_shift <= tx_next;
               tx_pend  <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[BW-2:0], 1'b0};
            end
         end
         if (tx_load) begin
            if ((bit_cnt_n == CW'(0)) && (fall_cnt_n == CW'(7))) begin
               tx_next <= {4'b0000, spi_in_cmem_out};
               tx_pend <= 1'b1;
            end else begin
               tx_shift <= BW'({4'b0000, spi_in_cmem_out} << fall_cnt_n);
            end
         end
      end
   end

   assign SPI_MISO = (state == IDLE) ? 1'bz : tx_shift[BW-1];

endmodule

// File: tb/tb_spi_cmem_bridge.sv
// tb_spi_cmem_bridge: directed SPI transactions against spi_cmem_bridge with a
// small registered cmem model and a strobe logger.
`timescale 1ns/1ps
module tb_spi_cmem_bridge;

   logic       clk200 = 1'b0;
   logic       reset;
   logic       cs_n;
   logic       sck;
   logic       mosi;
   wire        miso;
   logic       spi_read;
   logic       spi_write;
   logic [3:0] spi_address;
   logic [3:0] spi_out_cmem_in;
   logic [3:0] spi_in_cmem_out;

   int checks = 0;
   int errors = 0;
   int half   = 10;

   spi_cmem_bridge dut (
      .clk200          (clk200),
      .reset           (reset),
      .SPI_CS_n        (cs_n),
      .SPI_SCK         (sck),
      .SPI_MOSI        (mosi),
      .SPI_MISO        (miso),
      .spi_read        (spi_read),
      .spi_write       (spi_write),
      .spi_address     (spi_address),
      .spi_out_cmem_in (spi_out_cmem_in),
      .spi_in_cmem_out (spi_in_cmem_out)
   );

   always #2.5 clk200 = ~clk200;

   // cmem model: registered read data, plus a bench-side preload port.
   logic [3:0] mem [16];
   logic       load_en = 1'b0;
   logic [3:0] load_addr = '0;
   logic [3:0] load_data = '0;
   always @(posedge clk200) begin
      if (load_en) mem[load_addr] <= load_data;
      if (spi_write) mem[spi_address] <= spi_out_cmem_in;
      if (spi_read) spi_in_cmem_out <= mem[spi_address];
   end

   // Strobe logger, sampled mid-cycle.
   logic [3:0] rd_log [$];
   logic [7:0] wr_log [$];
   int         both_cnt = 0;
   int         wide_cnt = 0;
   logic       prev_rd  = 1'b0;
   logic       prev_wr  = 1'b0;
   always @(negedge clk200) begin
      if (spi_read) rd_log.push_back(spi_address);
      if (spi_write) wr_log.push_back({spi_address, spi_out_cmem_in});
      if (spi_read && spi_write) both_cnt++;
      if ((spi_read && prev_rd) || (spi_write && prev_wr)) wide_cnt++;
      prev_rd = spi_read;
      prev_wr = spi_write;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic mem_load(input logic [3:0] a, input logic [3:0] d);
      @(negedge clk200);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk200);
      load_en   = 1'b0;
   endtask

   // Mode 0: MOSI set while SCK low, MISO sampled just before the rise.
   task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
      r = '0;
      for (int i = 0; i < n; i++) begin
         mosi = b[7-i];
         repeat (half) @(negedge clk200);
         r[7-i] = miso;
         sck = 1'b1;
         repeat (half) @(negedge clk200);
         sck = 1'b0;
      end
   endtask

   task automatic cs_begin();
      @(negedge clk200);
      cs_n = 1'b0;
      repeat (4) @(negedge clk200);
   endtask

   task automatic cs_end();
      repeat (12) @(negedge clk200);
      cs_n = 1'b1;
      repeat (8) @(negedge clk200);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] r;
      int rb;
      int wb;

      reset = 1'b1;
      cs_n  = 1'b1;
      sck   = 1'b0;
      mosi  = 1'b0;
      repeat (3) @(negedge clk200);
      check("rst_read",  32'(spi_read), 0);
      check("rst_write", 32'(spi_write), 0);
      check("rst_addr",  32'(spi_address), 0);
      check("rst_wdata", 32'(spi_out_cmem_in), 0);
      reset = 1'b0;
      repeat (4) @(negedge clk200);

      // Single write: 0x15, 0x0A -> write (5, A)
      rb = rd_log.size(); wb = wr_log.size();
      cs_begin();
      spi_bits(8'h15, 8, r);
      check("sw_cmd_miso", 32'(r), 0);
      spi_bits(8'h0A, 8, r);
      check("sw_data_miso", 32'(r), 0);
      cs_end();
      check("sw_wr_cnt", 32'(wr_log.size() - wb), 1);
      check("sw_wr_val", 32'(wr_log[wb]), 32'h5A);
      check("sw_rd_cnt", 32'(rd_log.size() - rb), 0);

      // Single read of addr 12 holding 0x7, then an extra byte
      mem_load(4'd12, 4'h7);
      rb = rd_log.size(); wb = wr_log.size();
      cs_begin();
      spi_bits(8'h0C, 8, r);
      check("sr_cmd_miso", 32'(r), 0);
      spi_bits(8'h00, 8, r);
      check("sr_data_miso", 32'(r), 32'h07);
      spi_bits(8'h00, 8, r);
      check("sr_extra_miso", 32'(r), 0);
      cs_end();
      check("sr_rd_cnt", 32'(rd_log.size() - rb), 1);
      check("sr_rd_addr", 32'(rd_log[rb]), 12);
      check("sr_wr_cnt", 32'(wr_log.size() - wb), 0);

      // Burst read with wrap at full 25 MHz SCK
      mem_load(4'd14, 4'hB);
      mem_load(4'd15, 4'h3);
      mem_load(4'd0,  4'h6);
      mem_load(4'd1,  4'h9);
      half = 4;
      rb = rd_log.size(); wb = wr_log.size();
      cs_begin();
      spi_bits(8'h2E, 8, r);
      check("br_cmd_miso", 32'(r), 0);
      spi_bits(8'h00, 8, r);
      check("br_miso0", 32'(r), 32'h0B);
      spi_bits(8'h00, 8, r);
      check("br_miso1", 32'(r), 32'h03);
      spi_bits(8'h00, 8, r);
      check("br_miso2", 32'(r), 32'h06);
      cs_end();
      half = 10;
      check("br_rd_cnt", 32'(rd_log.size() - rb), 4);
      check("br_rd_a0", 32'(rd_log[rb]), 14);
      check("br_rd_a1", 32'(rd_log[rb+1]), 15);
      check("br_rd_a2", 32'(rd_log[rb+2]), 0);
      check("br_rd_a3", 32'(rd_log[rb+3]), 1);
      check("br_wr_cnt", 32'(wr_log.size() - wb), 0);

      // Burst write: upper nibble of each data byte dropped
      rb = rd_log.size(); wb = wr_log.size();
      cs_begin();
      spi_bits(8'h30, 8, r);
      spi_bits(8'hF1, 8, r);
      check("bw_miso", 32'(r), 0);
      spi_bits(8'h02, 8, r);
      spi_bits(8'h03, 8, r);
      cs_end();
      check("bw_wr_cnt", 32'(wr_log.size() - wb), 3);
      check("bw_wr0", 32'(wr_log[wb]), 32'h01);
      check("bw_wr1", 32'(wr_log[wb+1]), 32'h12);
      check("bw_wr2", 32'(wr_log[wb+2]), 32'h23);
      check("bw_rd_cnt", 32'(rd_log.size() - rb), 0);

      // Abort after 4 bits of a write command
      rb = rd_log.size(); wb = wr_log.size();
      cs_begin();
      spi_bits(8'h10, 4, r);
      cs_end();
      check("ab_wr_cnt", 32'(wr_log.size() - wb), 0);
      check("ab_rd_cnt", 32'(rd_log.size() - rb), 0);

      // Illegal opcode goes to DISCARD
      cs_begin();
      spi_bits(8'h9A, 8, r);
      check("il_cmd_miso", 32'(r), 0);
      spi_bits(8'h55, 8, r);
      check("il_data_miso", 32'(r), 0);
      cs_end();
      check("il_wr_cnt", 32'(wr_log.size() - wb), 0);
      check("il_rd_cnt", 32'(rd_log.size() - rb), 0);

      // Reset during the data byte of a write
      cs_begin();
      spi_bits(8'h13, 8, r);
      spi_bits(8'h0C, 4, r);
      @(negedge clk200);
      reset = 1'b1;
      repeat (2) @(negedge clk200);
      check("mr_read", 32'(spi_read), 0);
      check("mr_write", 32'(spi_write), 0);
      check("mr_addr", 32'(spi_address), 0);
      check("mr_wdata", 32'(spi_out_cmem_in), 0);
      cs_n = 1'b1;
      sck  = 1'b0;
      repeat (3) @(negedge clk200);
      reset = 1'b0;
      repeat (8) @(negedge clk200);
      check("mr_wr_cnt", 32'(wr_log.size() - wb), 0);

      // Normal write after reset release
      cs_begin();
      spi_bits(8'h19, 8, r);
      spi_bits(8'h06, 8, r);
      cs_end();
      check("pr_wr_cnt", 32'(wr_log.size() - wb), 1);
      check("pr_wr_val", 32'(wr_log[wb]), 32'h96);
      check("pr_rd_cnt", 32'(rd_log.size() - rb), 0);

      check("both_strobes", 32'(both_cnt), 0);
      check("wide_strobes", 32'(wide_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
